// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM encoding and default widths for the frame accumulator
package accum_pkg;
    localparam int N_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int ACC_W_DEF = N_DEF + 2;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/accum_sat_add.sv
// accum_sat_add: ACC_W accumulator adder with overflow detect; clamps when ACCUM_SAT_EN is defined, wraps otherwise
module accum_sat_add #(
    parameter int N = 8,
    parameter int ACC_W = N + 2
) (
    input  logic [ACC_W-1:0] a,
    input  logic [N:0]       b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W:0] full;
    // b never exceeds 2^ACC_W-1, so a single extra bit captures the true result
    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign ovf = full[ACC_W];
`ifdef ACCUM_SAT_EN
    assign sum = ovf ? '1 : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/accum_nbit.sv
// accum_nbit: frames len_in adder results into one total with valid/ready handshakes (ACCUM_SAT_EN selects clamping)
module accum_nbit
    import accum_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = N + 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [N-1:0]     sum_in,
    input  logic             carry_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid_out,
    input  logic             acc_ready_in,
    output logic             overflow_out,
    output logic             busy_out
);
    state_t state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] add_sum;
    logic add_ovf, xfer, hs, go;
    assign in_ready_out = state == ACCUM;
    assign acc_valid_out = state == HOLD;
    assign busy_out = state != IDLE;
    assign xfer = in_valid_in && in_ready_out;
    assign hs = acc_valid_out && acc_ready_in;
    // a start is only honoured from IDLE or on the cycle the finished total is consumed
    assign go = start_in && len_in != '0 && (state == IDLE || hs);
    accum_sat_add #(.N(N), .ACC_W(ACC_W)) u_add (
        .a(acc_out),
        .b({carry_in, sum_in}),
        .sum(add_sum),
        .ovf(add_ovf)
    );
    always_comb begin
        state_nxt = go ? ACCUM : hs ? IDLE : (xfer && cnt == LEN_W'(1)) ? HOLD : state;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            acc_out <= '0;
            overflow_out <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                acc_out <= '0;
                overflow_out <= 1'b0;
                cnt <= len_in;
            end else if (xfer) begin
                acc_out <= add_sum;
                overflow_out <= overflow_out | add_ovf;
                cnt <= cnt - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_accum_nbit.sv
// tb_accum_nbit: directed scoreboard bench for accum_nbit (N=8, ACC_W=10)
module tb_accum_nbit;
    logic clk_in = 1'b0, rst_n_in = 1'b0, start_in = 1'b0, carry_in = 1'b0;
    logic in_valid_in = 1'b0, acc_ready_in = 1'b0;
    logic [3:0] len_in = '0;
    logic [7:0] sum_in = '0;
    logic in_ready_out, acc_valid_out, overflow_out, busy_out;
    logic [9:0] acc_out;
    int total = 0, bad = 0;
    logic [10:0] q[$];
    logic [9:0] m_acc = '0;
    logic m_ovf = 1'b0;
    int m_cnt = 0;
    logic [9:0] held;

    accum_nbit #(.N(8), .LEN_W(4), .ACC_W(10)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .len_in(len_in),
        .sum_in(sum_in), .carry_in(carry_in), .in_valid_in(in_valid_in),
        .in_ready_out(in_ready_out), .acc_out(acc_out), .acc_valid_out(acc_valid_out),
        .acc_ready_in(acc_ready_in), .overflow_out(overflow_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_add(input logic [9:0] a, input logic [8:0] b);
        logic [10:0] f;
        f = {1'b0, a} + {2'b0, b};
`ifdef ACCUM_SAT_EN
        return {f[10], f[10] ? 10'h3FF : f[9:0]};
`else
        return f;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_acc"}, 32'(acc_out), 32'h0);
        chk({tag, "_valid"}, 32'(acc_valid_out), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow_out), 32'h0);
        chk({tag, "_ready"}, 32'(in_ready_out), 32'h0);
        chk({tag, "_busy"}, 32'(busy_out), 32'h0);
    endtask

    task automatic start_frame(input string tag, input logic [3:0] len);
        start_in = 1'b1;
        len_in = len;
        @(negedge clk_in);
        start_in = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = int'(len);
        chk({tag, "_start_ready"}, 32'(in_ready_out), 32'h1);
        chk({tag, "_start_acc"}, 32'(acc_out), 32'h0);
    endtask

    task automatic xfer(input string tag, input logic [7:0] s, input logic c);
        logic [10:0] r;
        chk({tag, "_xfer_ready"}, 32'(in_ready_out), 32'h1);
        sum_in = s;
        carry_in = c;
        in_valid_in = 1'b1;
        r = model_add(m_acc, {c, s});
        m_acc = r[9:0];
        m_ovf = m_ovf | r[10];
        m_cnt--;
        if (m_cnt == 0) q.push_back({m_ovf, m_acc});
        @(negedge clk_in);
        in_valid_in = 1'b0;
    endtask

    task automatic collect(input string tag);
        logic [10:0] e;
        int w = 0;
        while (acc_valid_out !== 1'b1 && w < 10) begin
            @(negedge clk_in);
            w++;
        end
        chk({tag, "_latency"}, 32'(w), 32'h0);
        chk({tag, "_valid"}, 32'(acc_valid_out), 32'h1);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        chk({tag, "_acc"}, 32'(acc_out), 32'(e[9:0]));
        chk({tag, "_ovf"}, 32'(overflow_out), 32'(e[10]));
    endtask

    task automatic release_frame(input string tag);
        held = acc_out;
        acc_ready_in = 1'b1;
        @(negedge clk_in);
        acc_ready_in = 1'b0;
        chk({tag, "_rel_valid"}, 32'(acc_valid_out), 32'h0);
        chk({tag, "_rel_busy"}, 32'(busy_out), 32'h0);
        chk({tag, "_rel_acc"}, 32'(acc_out), 32'(held));
    endtask

    initial begin
        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            start_in = 1'($urandom);
            len_in = 4'($urandom);
            sum_in = 8'($urandom);
            carry_in = 1'($urandom);
            in_valid_in = 1'($urandom);
            acc_ready_in = 1'($urandom);
            chk_idle("rst_hold");
        end
        start_in = 1'b0; in_valid_in = 1'b0; acc_ready_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk_idle("post_rst");

        // plain frame
        start_frame("f1", 4'd3);
        xfer("f1a", 8'h05, 1'b0);
        xfer("f1b", 8'h03, 1'b0);
        xfer("f1c", 8'h0E, 1'b0);
        collect("f1");
        chk("f1_lit", 32'(acc_out), 32'h016);
        release_frame("f1");

        // overflowing frame
        start_frame("f2", 4'd3);
        for (int i = 0; i < 3; i++) xfer("f2", 8'hFF, 1'b1);
        collect("f2");
`ifdef ACCUM_SAT_EN
        chk("f2_lit", 32'(acc_out), 32'h3FF);
`else
        chk("f2_lit", 32'(acc_out), 32'h1FD);
`endif
        chk("f2_ovf_lit", 32'(overflow_out), 32'h1);

        // downstream stall then back-to-back start
        held = acc_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("stall_acc", 32'(acc_out), 32'(held));
            chk("stall_ready", 32'(in_ready_out), 32'h0);
            chk("stall_valid", 32'(acc_valid_out), 32'h1);
        end
        acc_ready_in = 1'b1;
        start_frame("b2b", 4'd2);
        acc_ready_in = 1'b0;
        chk("b2b_valid", 32'(acc_valid_out), 32'h0);
        chk("b2b_ovf", 32'(overflow_out), 32'h0);
        xfer("b2b_a", 8'h20, 1'b0);
        xfer("b2b_b", 8'h01, 1'b1);
        collect("b2b");
        chk("b2b_lit", 32'(acc_out), 32'h121);
        release_frame("b2b");

        // reset in the middle of a frame
        start_frame("mid", 4'd4);
        xfer("mid_a", 8'h11, 1'b0);
        xfer("mid_b", 8'h22, 1'b0);
        #2 rst_n_in = 1'b0;
        #1 chk_idle("mid_rst");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        start_frame("after", 4'd1);
        xfer("after", 8'h10, 1'b0);
        collect("after");
        chk("after_lit", 32'(acc_out), 32'h010);
        release_frame("after");

        // ignored starts
        held = acc_out;
        start_in = 1'b1;
        len_in = 4'd0;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("len0_busy", 32'(busy_out), 32'h0);
        chk("len0_ready", 32'(in_ready_out), 32'h0);
        chk("len0_acc", 32'(acc_out), 32'(held));
        start_frame("ign", 4'd2);
        xfer("ign_a", 8'h07, 1'b0);
        start_in = 1'b1;
        len_in = 4'd5;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("ign_acc", 32'(acc_out), 32'h007);
        chk("ign_ready", 32'(in_ready_out), 32'h1);
        xfer("ign_b", 8'h09, 1'b0);
        collect("ign");
        chk("ign_lit", 32'(acc_out), 32'h010);
        release_frame("ign");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accum_nbit.md
ACCUM_NBIT -- requirements
Module: accum_nbit

Interface
REQ-001 Parameter: N, default 8, width of the adder sum consumed by this block.
REQ-002 Parameter: LEN_W, default 4, width of the frame-length input.
REQ-003 Parameter: ACC_W, default N+2, accumulator width.
REQ-004 Port: clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Port: start_in  input  1  begin a frame, sampled only in IDLE or on a HOLD handshake cycle.
REQ-007 Port: len_in  input  LEN_W  number of adder results in the frame, captured on an accepted start.
REQ-008 Port: sum_in  input  N  sum from the upstream N-bit adder.
REQ-009 Port: carry_in  input  1  carry from the upstream N-bit adder.
REQ-010 Port: in_valid_in  input  1  sum_in/carry_in valid.
REQ-011 Port: in_ready_out  output  1  block accepts a result this cycle.
REQ-012 Port: acc_out  output  ACC_W  accumulated frame total.
REQ-013 Port: acc_valid_out  output  1  acc_out holds a completed frame.
REQ-014 Port: acc_ready_in  input  1  downstream consumes acc_out.
REQ-015 Port: overflow_out  output  1  frame total exceeded ACC_W bits.
REQ-016 Port: busy_out  output  1  high in ACCUM or HOLD.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM, HOLD.
REQ-018 IDLE->ACCUM on start_in=1 with len_in!=0; accumulator, overflow_out cleared, counter loaded with len_in.
REQ-019 start_in with len_in=0, or start_in in ACCUM, SHALL be ignored.
REQ-020 in_ready_out SHALL be 1 exactly when state is ACCUM.
REQ-021 A transfer occurs when in_valid_in and in_ready_out are both 1; acc += zero-extended {carry_in,sum_in} (N+1 bits); counter decrements.
REQ-022 The transfer that brings the counter to 0 SHALL move the FSM to HOLD; acc_valid_out rises the next cycle with the final total (one-cycle latency).
REQ-023 In HOLD, acc_out, acc_valid_out, overflow_out SHALL stay stable until acc_ready_in=1.
REQ-024 HOLD handshake without start_in SHALL return to IDLE; acc_valid_out falls next cycle; acc_out retains last value.
REQ-025 HOLD handshake with start_in=1 and len_in!=0 SHALL enter ACCUM directly (back-to-back frames, accumulator cleared).
REQ-026 overflow_out SHALL be sticky within a frame: set on any addition whose true result exceeds 2^ACC_W-1.

Reset
REQ-027 On rst_n_in=0, asynchronously: state IDLE, acc_out=0, acc_valid_out=0, overflow_out=0, in_ready_out=0, busy_out=0, counter=0.
REQ-028 Reset mid-frame SHALL discard the partial total; the next frame after release SHALL be unaffected.

Configuration
REQ-029 Macro ACCUM_SAT_EN: defined -> an overflowing addition SHALL clamp acc to 2^ACC_W-1 and hold it there; undefined -> the accumulator SHALL wrap modulo 2^ACC_W; overflow_out behaves identically in both.

Structure
REQ-030 Shared package accum_pkg SHALL hold the FSM state encoding (IDLE=0, ACCUM=1, HOLD=2) and default N/LEN_W/ACC_W constants.
REQ-031 One sub-module, accum_sat_add (ACC_W adder with overflow detect and optional clamp), is natural; the FSM and counter stay in accum_nbit.

Verification (N=8, ACC_W=10)
REQ-032 Reset held with inputs toggling -> all outputs 0, in_ready_out=0.
REQ-033 start len=3; results (0x05,0),(0x03,0),(0x0E,0) -> acc_out=0x016, overflow_out=0, acc_valid_out one cycle after third transfer.
REQ-034 start len=3; (0xFF,1) x3 -> wrap build: acc_out=0x1FD, overflow_out=1; ACCUM_SAT_EN build: acc_out=0x3FF, overflow_out=1.
REQ-035 Frame done, acc_ready_in low 5 cycles -> acc_out stable, in_ready_out=0; then acc_ready_in=1 with start len=2 -> ACCUM next cycle, acc cleared.
REQ-036 Reset asserted after 2 of 4 transfers -> immediate IDLE, outputs 0; following len=1 frame with (0x10,0) -> acc_out=0x010.
REQ-037 start with len_in=0 in IDLE, and start during ACCUM -> ignored; state, counter, acc_out unchanged.
